// File: rtl/flag_pkg.sv
// Shared constants for the status-flag unit.
// Flag bit positions, branch condition codes, default opcode masks.
package flag_pkg;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [2:0] COND_NE = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_GT = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_GE = 3'd4;
  localparam logic [2:0] COND_LE = 3'd5;
  localparam logic [2:0] COND_OV = 3'd6;
  localparam logic [2:0] COND_UN = 3'd7;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_PADDSB = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;

  // Opcodes with op[3]=1 are non-ALU and touch no flag.
  localparam logic [15:0] DEF_Z_MASK = 16'h00FD;
  localparam logic [15:0] DEF_V_MASK = 16'h0005;
  localparam logic [15:0] DEF_N_MASK = 16'h0005;

  // Overlay masked bits of val onto cur.
  function automatic logic [2:0] merge(
    input logic [2:0] cur,
    input logic [2:0] mask,
    input logic [2:0] val
  );
    return (cur & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/flag_unit_pipe_cond.sv
// Branch condition decoder: flags {Z,V,N} + cond code -> true/false.
// Ports: eff (flags seen by branch), cond (code), hit (condition true).
module flag_cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] eff,
  input  logic [2:0] cond,
  output logic       hit
);

  logic z, v, n;

  assign z = eff[FLAG_Z];
  assign v = eff[FLAG_V];
  assign n = eff[FLAG_N];

  always_comb begin
    hit = 1'b0;
    unique case (cond)
      COND_NE: hit = ~z;
      COND_EQ: hit = z;
      COND_GT: hit = ~z & ~n;
      COND_LT: hit = n;
      COND_GE: hit = z | ~n;
      COND_LE: hit = n | z;
      COND_OV: hit = v;
      COND_UN: hit = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_unit_pipe.sv
// Z/V/N flag unit: one-entry pending stage, masked commit, branch eval.
// Ports: EX capture (ex_*, alu_*, stall, flush), ID branch (br_*), flags.
module flag_unit_pipe
  import flag_pkg::*;
#(
  parameter int OP_W = 4,
  parameter logic [(2**OP_W)-1:0] UPD_Z_MASK = 16'h00FD,
  parameter logic [(2**OP_W)-1:0] UPD_V_MASK = 16'h0005,
  parameter logic [(2**OP_W)-1:0] UPD_N_MASK = 16'h0005,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [OP_W-1:0] ex_opcode,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  output logic            br_taken,
  output logic            br_stall,
  output logic [2:0]      flags,
  output logic            pend_valid
);

  localparam logic BYP = (BYPASS != 0);

  logic       cap;
  logic [2:0] cap_mask;
  logic [2:0] pend_mask;
  logic [2:0] pend_val;
  logic [2:0] eff;
  logic       hit;

  assign cap = ex_valid & ~stall & ~flush;

  assign cap_mask = {UPD_Z_MASK[ex_opcode],
                     UPD_V_MASK[ex_opcode],
                     UPD_N_MASK[ex_opcode]};

  // The pending entry is older than EX, so it commits
  // regardless of stall/flush; capture and commit share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_mask  <= 3'b000;
      pend_val   <= 3'b000;
      flags      <= 3'b000;
    end else begin
      pend_valid <= cap;
      if (cap) begin
        pend_mask <= cap_mask;
        pend_val  <= {alu_z, alu_v, alu_n};
      end
      if (pend_valid)
        flags <= merge(flags, pend_mask, pend_val);
    end
  end

  always_comb begin
    eff = flags;
    if (BYP && pend_valid)
      eff = merge(flags, pend_mask, pend_val);
  end

  flag_cond_eval u_cond (
    .eff  (eff),
    .cond (br_cond),
    .hit  (hit)
  );

  assign br_stall = br_valid & pend_valid & ~BYP;
  assign br_taken = br_valid & ~br_stall & hit;

endmodule

// File: doc/flag_unit_pipe.md
Name: flag_unit_pipe

Overview:
- Parametrised next-generation processor status-flag unit: holds the architectural Z/V/N flags and updates them selectively per opcode.
- Per-flag update rules come from opcode bitmask parameters instead of fixed decode.
- Adds a one-entry pending-update stage with stall/flush handling, and a branch-condition evaluator with optional bypass of the pending update.
- Sits between the EX-stage ALU and the ID-stage branch logic.

Parameters:
- OP_W, 4: opcode width.
- UPD_Z_MASK, 16'h00FD: bit k=1 means opcode k updates Z. Width 2**OP_W.
- UPD_V_MASK, 16'h0005: bit k=1 means opcode k updates V.
- UPD_N_MASK, 16'h0005: bit k=1 means opcode k updates N.
- BYPASS, 1: 1 = branch evaluation sees the pending update; 0 = branch stalls while an update is pending.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- ex_valid, input, 1: valid ALU result this cycle.
- ex_opcode, input, OP_W: opcode of the EX instruction.
- alu_z, input, 1: Z flag from the ALU.
- alu_v, input, 1: V flag from the ALU.
- alu_n, input, 1: N flag from the ALU.
- stall, input, 1: EX stage frozen; do not capture.
- flush, input, 1: EX instruction squashed; do not capture.
- br_valid, input, 1: branch present in ID.
- br_cond, input, 3: branch condition code.
- br_taken, output, 1: branch condition true (combinational).
- br_stall, output, 1: branch must wait (only when BYPASS=0).
- flags, output, 3: architectural {Z,V,N}.
- pend_valid, output, 1: an update is in the pending stage.

Behaviour:
- Reset (async, rst_n=0): flags=3'b000, pending entry cleared (pend_valid=0, pending mask=0).
- br_taken and br_stall are 0 whenever br_valid=0.
- Capture: when ex_valid & ~stall & ~flush, the pending stage registers:
  - mask m = {UPD_Z_MASK[op], UPD_V_MASK[op], UPD_N_MASK[op]}
  - values {alu_z, alu_v, alu_n}
  - pend_valid <= 1
- Otherwise pend_valid <= 0 the next cycle.
- A capture with m=000 still sets pend_valid=1 but changes no flag.
- Commit: every cycle pend_valid=1, for each bit i with m[i]=1, flags[i] <= pending value[i]; bits with m[i]=0 hold.
- Commit is unconditional. stall and flush never affect an entry already pending, because it is older than the EX instruction.
- Latency: ALU flags are visible on `flags` 2 cycles after capture, and to the branch evaluator 1 cycle after capture when BYPASS=1.
- Effective flags E:
  - BYPASS=1: E[i] = (pend_valid & m[i]) ? pending value[i] : flags[i].
  - BYPASS=0: E = flags.
- Condition decode on E (Z,V,N), with br_taken = br_valid & cond:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GE: Z | ~N
  - 101 LE: N | Z
  - 110 OV: V
  - 111 UN: 1
- br_stall = br_valid & pend_valid & (BYPASS==0). When br_stall=1, br_taken is forced to 0.
- Same-cycle ALU inputs are never bypassed to the branch. The branch sees only state older than the current EX instruction.
- Simultaneous capture and commit: the commit of the old entry and the capture of the new entry both occur on the same edge. There is no bubble, so back-to-back ALU ops update on consecutive cycles.
- Opcode index beyond the mask width is impossible by construction (mask width = 2**OP_W).
- Reset mid-operation: a pending entry is discarded and never committed.

Decomposition:
- Package flag_pkg holds:
  - flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0)
  - cond-code localparams COND_NE..COND_UN
  - default mask constants for the 4-bit ISA: ADD=0, PADDSB=1, SUB=2, non-ALU = op[3]=1
- One sub-module: flag_cond_eval, a combinational cond decode of (E, br_cond) to a taken bit.
- Top module holds the pending register, the architectural register, the merge logic and the stall logic.

Test Plan:
- Reset then ADD with z=1,v=1,n=1, ex_valid=1 -> pend_valid=1 next cycle; flags=3'b111 two cycles after capture.
- PADDSB (op 1) with z=1 after flags=000 -> flags remain 000: Z not updated, V/N not updated.
- SUB (op 2) capturing n=1,z=0, then EQ/LT branch the next cycle with BYPASS=1 -> br_taken LT=1, EQ=0 before `flags` changes.
- Same case with BYPASS=0 -> br_stall=1 and br_taken=0 for 1 cycle, then br_taken=1 from committed flags.
- Capture with flush=1, or with stall=1 -> pend_valid stays 0 and flags unchanged. Pending entry followed by stall/flush the next cycle -> entry still commits.
- Back-to-back ADD (z=1) then op 3 (z=0) -> Z goes 1 then 0 on consecutive edges. Assert rst_n=0 mid-pending -> flags=000, pend_valid=0 immediately (async).
